result_gather: RTL and testbench

RESULT_GATHER -- requirements
Module: result_gather

---
 rtl/paillier_pkg.sv | 9 +
 rtl/gather_skid_buf.sv | 27 ++
 rtl/result_gather.sv | 85 ++++++++
 tb/tb_result_gather.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/paillier_pkg.sv
// paillier_pkg: shared gather types and default geometry for the paillier result path
package paillier_pkg;
  localparam int BLOCK_COUNT_DEF = 18;
  localparam int K_DEF = 128;
  localparam int N_DEF = 32;
  localparam int GATHER_ID_W = $clog2(BLOCK_COUNT_DEF);
  localparam int CNT_W = $clog2(N_DEF) + 1;
  typedef enum logic [1:0] {IDLE, ARB, DRAIN} gather_state_e;
endpackage

// File: rtl/gather_skid_buf.sv
// gather_skid_buf: 2-entry in-order buffer, head always in e0
module gather_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [W-1:0] e0, e1;
  always_ff @(posedge clk) begin
    if (rst) begin
      e0 <= '0;
      e1 <= '0;
      occ <= '0;
    end else begin
      occ <= occ + {1'b0, push} - {1'b0, pop};
      if (pop && occ == 2'd2) e0 <= e1;
      else if (push && (pop || occ == 2'd0)) e0 <= din;
      if (push && (occ == 2'd2 || (occ == 2'd1 && !pop))) e1 <= din;
    end
  end
  assign dout = e0;
endmodule

// File: rtl/result_gather.sv
// result_gather: round-robin drain of full-result FIFOs into one tagged output stream
module result_gather import paillier_pkg::*; #(
  parameter int BLOCK_COUNT = BLOCK_COUNT_DEF,
  parameter int K = K_DEF,
  parameter int N = N_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [CNT_W-1:0]       fifo_rd_cnt [BLOCK_COUNT],
  output logic [BLOCK_COUNT-1:0] fifo_rd_rdy,
  input  logic [K-1:0]           fifo_rd_dout [BLOCK_COUNT],
  output logic [K-1:0]           m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [GATHER_ID_W-1:0] m_id,
  output logic [15:0]            results_done,
  output logic                   busy
);
  gather_state_e state, state_n;
  logic [GATHER_ID_W-1:0] rr_ptr, gnt, pick, j;
  logic [CNT_W-1:0] issue_cnt, recv_cnt;
  logic found, in_flight, rd, pop, grant;
  logic [1:0] occ;
  always_comb begin
    found = 1'b0;
    pick = '0;
    j = '0;
    for (int k = 0; k < BLOCK_COUNT; k++) begin
      j = GATHER_ID_W'((int'(rr_ptr) + k) % BLOCK_COUNT);
      if (!found && fifo_rd_cnt[j] >= CNT_W'(N)) begin
        found = 1'b1;
        pick = j;
      end
    end
  end
  assign grant = state == ARB && enable && found;
  assign pop = m_valid && m_ready;
  // an issued read lands one cycle later, so count it against buffer space now
  assign rd = state == DRAIN && issue_cnt < CNT_W'(N) &&
              ({1'b0, occ} + {2'b0, in_flight} < 3'd2 + {2'b0, pop});
  assign fifo_rd_rdy = rd ? (BLOCK_COUNT'(1) << gnt) : '0;
  always_comb begin
    state_n = state;
    if (state == IDLE && enable) state_n = ARB;
    if (state == ARB) state_n = !enable ? IDLE : found ? DRAIN : ARB;
    if (state == DRAIN && pop && m_last) state_n = enable ? ARB : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      gnt <= '0;
      issue_cnt <= '0;
      recv_cnt <= '0;
      in_flight <= 1'b0;
      results_done <= '0;
    end else begin
      state <= state_n;
      in_flight <= rd;
      if (grant) begin
        gnt <= pick;
        rr_ptr <= (pick == GATHER_ID_W'(BLOCK_COUNT - 1)) ? '0 : pick + GATHER_ID_W'(1);
        issue_cnt <= '0;
        recv_cnt <= '0;
      end else begin
        if (rd) issue_cnt <= issue_cnt + CNT_W'(1);
        if (in_flight) recv_cnt <= recv_cnt + CNT_W'(1);
      end
      if (pop && m_last) results_done <= results_done + 16'd1;
    end
  end
  gather_skid_buf #(.W(K + GATHER_ID_W + 1)) u_buf (
    .clk (clk),
    .rst (rst),
    .push(in_flight),
    .pop (pop),
    .din ({fifo_rd_dout[gnt], gnt, recv_cnt == CNT_W'(N - 1)}),
    .dout({m_data, m_id, m_last}),
    .occ (occ)
  );
  assign m_valid = occ != 2'd0;
  assign busy = state != IDLE || m_valid;
endmodule

// File: tb/tb_result_gather.sv
// tb_result_gather: FIFO source model, round-robin scoreboard, vector table and directed corners
module tb_result_gather;
  import paillier_pkg::*;
  localparam int BC = 18;
  localparam int K = 128;
  localparam int N = 32;
  logic clk = 0, rst = 1, enable = 0, m_ready = 0;
  logic [CNT_W-1:0] cnt [BC];
  logic [BC-1:0] rdy;
  logic [K-1:0] dout [BC];
  logic [K-1:0] m_data;
  logic m_valid, m_last, busy;
  logic [GATHER_ID_W-1:0] m_id;
  logic [15:0] results_done;
  always #5 clk = ~clk;
  result_gather #(.BLOCK_COUNT(BC), .K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rd_cnt(cnt), .fifo_rd_rdy(rdy),
    .fifo_rd_dout(dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_id(m_id), .results_done(results_done), .busy(busy)
  );
  int passed = 0, total = 0;
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  logic [K-1:0] src_q [BC][$];
  logic [K-1:0] exp_q [BC][$];
  int rd_total = 0, acc_total = 0, max_out = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // source FIFOs: data appears the cycle after a read pulse, count tracks contents
  always @(posedge clk) begin
    if (rst) rd_total = 0;
    else if (rdy != 0) rd_total++;
    for (int i = 0; i < BC; i++) begin
      if (rst) begin
        src_q[i].delete();
        dout[i] <= '0;
      end else if (rdy[i]) begin
        if (src_q[i].size() > 0) dout[i] <= src_q[i].pop_front();
        else dout[i] <= 'x;
      end
      cnt[i] <= CNT_W'(src_q[i].size() > 63 ? 63 : src_q[i].size());
    end
  end
  // scoreboard: each result comes whole from the next eligible source after the last one served
  int widx = 0, mptr = 0, cur_id = 0, grant_log[$];
  logic pv = 0;
  logic [K+GATHER_ID_W:0] pvals;
  logic [K-1:0] w;
  always @(negedge clk) begin
    if (rst) begin
      widx = 0; mptr = 0; acc_total = 0; max_out = 0; pv = 0;
      grant_log.delete();
      for (int i = 0; i < BC; i++) exp_q[i].delete();
    end else begin
      if (pv) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_word", {m_data, m_id, m_last}, pvals);
      end
      if (rd_total - acc_total > max_out) max_out = rd_total - acc_total;
      if (m_valid && m_ready) begin
        if (widx == 0) begin
          cur_id = -1;
          for (int k = 0; k < BC; k++)
            if (cur_id < 0 && exp_q[(mptr + k) % BC].size() >= N) cur_id = (mptr + k) % BC;
          check("grant_eligible", cur_id >= 0, 1'b1);
          if (cur_id < 0) cur_id = int'(m_id);
          mptr = (cur_id + 1) % BC;
        end
        check("m_id", m_id, cur_id);
        w = 'x;
        if (exp_q[cur_id].size() > 0) w = exp_q[cur_id].pop_front();
        check("m_data", m_data, w);
        check("m_last", m_last, widx == N - 1);
        if (widx == N - 1) grant_log.push_back(cur_id);
        widx = (widx + 1) % N;
        acc_total++;
      end
      pv = m_valid && !m_ready;
      pvals = {m_data, m_id, m_last};
    end
  end
  task automatic push_words(input int idx, input int n);
    logic [K-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      src_q[idx].push_back(v);
      exp_q[idx].push_back(v);
    end
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; enable = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic wait_acc(input int target, input int budget, input string name);
    for (int c = 0; c < budget && acc_total < target; c++) @(posedge clk);
    #1 check(name, acc_total >= target, 1'b1);
  endtask
  typedef struct {int idx; int words; int exp_rd; int exp_acc; int exp_done; int exp_lat; int exp_span;} vec_t;
  vec_t vt [5];
  int r, v, l, pulses, bad, nres, lat, span;
  logic [3:0] pat = 4'b1001;
  initial begin
    vt[0] = '{3, 32, 32, 32, 1, 2, N + 1};
    vt[1] = '{5, 31, 0, 0, 0, -1, -1};
    vt[2] = '{17, 32, 32, 32, 1, 2, N + 1};
    vt[3] = '{0, 40, 32, 32, 1, 2, N + 1};
    vt[4] = '{9, 0, 0, 0, 0, -1, -1};
    do_reset();
    check("rst_rdy", rdy, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_id", m_id, 0);
    check("rst_data", m_data, 0);
    check("rst_done", results_done, 0);
    check("rst_busy", busy, 0);
    // single-source vectors: pulses, words, results and timing from the first read pulse
    for (int t = 0; t < 5; t++) begin
      do_reset();
      push_words(vt[t].idx, vt[t].words);
      m_ready = 1; enable = 1;
      r = -1; v = -1; l = -1; pulses = 0; bad = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (!$onehot0(rdy)) bad++;
        if (rdy != 0) pulses++;
        if (rdy != 0 && r < 0) r = c;
        if (m_valid && v < 0) v = c;
        if (m_valid && m_ready && m_last) l = c;
      end
      lat = (r < 0 || v < 0) ? -1 : v - r;
      span = (r < 0 || l < 0) ? -1 : l - r;
      check($sformatf("vec%0d_pulses", t), pulses, vt[t].exp_rd);
      check($sformatf("vec%0d_words", t), acc_total, vt[t].exp_acc);
      check($sformatf("vec%0d_done", t), results_done, vt[t].exp_done);
      check($sformatf("vec%0d_lat", t), lat, vt[t].exp_lat);
      check($sformatf("vec%0d_span", t), span, vt[t].exp_span);
      check($sformatf("vec%0d_onehot", t), bad, 0);
      enable = 0;
    end
    // every source full: grants sweep 0..17, then pointer wraps back to 0
    do_reset();
    for (int i = 0; i < BC; i++) push_words(i, N);
    m_ready = 1; enable = 1;
    wait_acc(BC * N, BC * 40 + 50, "all_drain");
    check("all_grants", grant_log.size(), BC);
    for (int i = 0; i < BC && i < grant_log.size(); i++) check($sformatf("order%0d", i), grant_log[i], i);
    push_words(5, N);
    push_words(0, N);
    wait_acc((BC + 2) * N, 150, "wrap_drain");
    check("wrap_first", grant_log.size() > BC ? grant_log[BC] : -1, 0);
    check("wrap_second", grant_log.size() > BC + 1 ? grant_log[BC + 1] : -1, 5);
    check("wrap_done", results_done, BC + 2);
    // backpressure 1,0,0,1
    do_reset();
    push_words(4, N);
    push_words(7, N);
    enable = 1;
    for (int c = 0; c < 400 && acc_total < 2 * N; c++) begin
      @(posedge clk); #1;
      m_ready = pat[3 - c % 4];
    end
    @(posedge clk); #1;
    check("bp_words", acc_total, 2 * N);
    check("bp_done", results_done, 2);
    check("bp_outstanding", max_out <= 2, 1'b1);
    // 31 words never eligible; the 32nd grants promptly
    do_reset();
    push_words(5, N - 1);
    m_ready = 1; enable = 1;
    pulses = 0;
    repeat (10) begin @(negedge clk); if (rdy != 0) pulses++; end
    check("short_no_rd", pulses, 0);
    push_words(5, 1);
    for (int c = 0; c < 4 && cnt[5] != CNT_W'(N); c++) @(negedge clk);
    check("short_cnt", cnt[5], N);
    r = -1;
    for (int c = 0; c < 4 && r < 0; c++) begin if (rdy[5]) r = c; else @(negedge clk); end
    check("short_grant_lat", r >= 0 && r <= 1, 1'b1);
    wait_acc(N, 60, "short_drain");
    // enable dropped mid-result
    do_reset();
    push_words(2, 2 * N);
    m_ready = 1; enable = 1;
    wait_acc(10, 40, "en_reach10");
    enable = 0;
    repeat (80) @(posedge clk);
    #1;
    check("en_words", acc_total, N);
    check("en_done", results_done, 1);
    check("en_busy", busy, 0);
    check("en_left", src_q[2].size(), N);
    // reset mid-result
    do_reset();
    push_words(6, N);
    m_ready = 1; enable = 1;
    wait_acc(16, 40, "rst_reach16");
    rst = 1;
    @(posedge clk); #1;
    check("mid_rst_rdy", rdy, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_id", m_id, 0);
    check("mid_rst_data", m_data, 0);
    check("mid_rst_done", results_done, 0);
    check("mid_rst_busy", busy, 0);
    rst = 0;
    // randomized loads and backpressure
    for (int round = 0; round < 2; round++) begin
      do_reset();
      nres = 0;
      for (int i = 0; i < BC; i++) begin
        r = $urandom_range(0, 2);
        push_words(i, r * N + $urandom_range(0, N - 1));
        nres += r;
      end
      enable = 1;
      for (int c = 0; c < 5000 && acc_total < nres * N; c++) begin
        @(posedge clk); #1;
        m_ready = $urandom_range(0, 3) != 0;
      end
      m_ready = 1;
      check($sformatf("rand%0d_words", round), acc_total, nres * N);
      check($sformatf("rand%0d_done", round), results_done, nres);
      check($sformatf("rand%0d_outstanding", round), max_out <= 2, 1'b1);
      enable = 0;
      repeat (5) @(posedge clk);
      #1 check($sformatf("rand%0d_idle", round), busy, 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
